// File: rtl/nec_prefetch_pkg.sv
// Shared types for the NEC prefetch-queue controller.
// Holds the FSM state encoding, queue depth and the fetch-size helper.
package nec_prefetch_pkg;

   typedef enum logic [1:0] {
      PF_IDLE,
      PF_REQ,
      PF_WAIT,
      PF_DISCARD
   } prefetch_state_e;

   localparam int IPQ_DEPTH = 8;
   localparam int IPQ_LEN_W = 4;

   // An odd fetch pointer only needs room for one byte; even pointers fetch a word.
   function automatic logic [IPQ_LEN_W-1:0] fetchNeed(input logic oddPc, input int wordFree);
      return oddPc ? IPQ_LEN_W'(1) : IPQ_LEN_W'(wordFree);
   endfunction

endpackage

// File: rtl/nec_prefetch.sv
// Prefetch-queue controller: owns the 8-byte IPQ, fetches code from the BIU at PS:fetch_pc
// and retires bytes as the decoder consumes them; a flush restarts filling at new_pc.
module nec_prefetch
   import nec_prefetch_pkg::*;
#(
   parameter int DEPTH     = IPQ_DEPTH,
   parameter int ADDR_W    = 20,
   parameter int WORD_FREE = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ce,
   input  logic                   flush,
   input  logic [15:0]            new_pc,
   input  logic [15:0]            ps,
   input  logic [3:0]             consume,
   output logic [DEPTH-1:0][7:0]  ipq,
   output logic [3:0]             ipq_len,
   output logic                   fetch_req,
   output logic [ADDR_W-1:0]      fetch_addr,
   output logic                   fetch_word,
   input  logic                   fetch_ack,
   input  logic                   fetch_rvalid,
   input  logic [15:0]            fetch_rdata
);

   localparam int IDX_W = $clog2(DEPTH);

   prefetch_state_e          r_state;
   logic [DEPTH-1:0][7:0]    r_ipq;
   logic [3:0]               r_len;
   logic [15:0]              r_headPc;
   logic                     r_fetchReq;
   logic [ADDR_W-1:0]        r_fetchAddr;
   logic                     r_fetchWord;

   logic [15:0]              w_fetchPc;
   logic [3:0]               w_lenAfter;
   logic [3:0]               w_free;
   logic [3:0]               w_written;
   logic [3:0]               w_lenNext;
   logic [ADDR_W-1:0]        w_fetchAddr;
   logic [IDX_W-1:0]         w_wrIdx;
   logic [IDX_W-1:0]         w_wrIdxHi;

   // fetch_pc is kept implicit: it always sits ipq_len bytes past the decoder pc.
   assign w_fetchPc   = r_headPc + 16'(r_len);
   assign w_lenAfter  = r_len - consume;
   assign w_free      = 4'(DEPTH) - w_lenAfter;
   assign w_written   = (r_state == PF_WAIT && fetch_rvalid) ? (r_fetchWord ? 4'd2 : 4'd1) : 4'd0;
   assign w_lenNext   = w_lenAfter + w_written;
   assign w_fetchAddr = ADDR_W'({ps, 4'h0}) + ADDR_W'(w_fetchPc);
   assign w_wrIdx     = w_fetchPc[IDX_W-1:0];
   assign w_wrIdxHi   = w_wrIdx + IDX_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= PF_IDLE;
         r_ipq       <= '0;
         r_len       <= '0;
         r_headPc    <= '0;
         r_fetchReq  <= 1'b0;
         r_fetchAddr <= '0;
         r_fetchWord <= 1'b0;
      end else if (ce) begin
         if (flush) begin
            r_headPc   <= new_pc;
            r_len      <= '0;
            r_fetchReq <= 1'b0;
            // A fetch the BIU has already taken must still be drained before the next one.
            unique case (r_state)
               PF_REQ:     r_state <= fetch_ack ? PF_DISCARD : PF_IDLE;
               PF_WAIT:    r_state <= fetch_rvalid ? PF_IDLE : PF_DISCARD;
               PF_DISCARD: r_state <= fetch_rvalid ? PF_IDLE : PF_DISCARD;
               default:    r_state <= PF_IDLE;
            endcase
         end else begin
            r_headPc <= r_headPc + 16'(consume);
            r_len    <= w_lenNext;
            unique case (r_state)
               PF_IDLE: begin
                  if (w_free >= fetchNeed(w_fetchPc[0], WORD_FREE)) begin
                     r_fetchReq  <= 1'b1;
                     r_fetchAddr <= w_fetchAddr;
                     r_fetchWord <= ~w_fetchPc[0];
                     r_state     <= PF_REQ;
                  end
               end
               PF_REQ: begin
                  if (fetch_ack) begin
                     r_fetchReq <= 1'b0;
                     r_state    <= PF_WAIT;
                  end
               end
               PF_WAIT: begin
                  if (fetch_rvalid) begin
                     if (r_fetchWord) begin
                        r_ipq[w_wrIdx]   <= fetch_rdata[7:0];
                        r_ipq[w_wrIdxHi] <= fetch_rdata[15:8];
                     end else begin
                        r_ipq[w_wrIdx]   <= fetch_rdata[15:8];
                     end
                     r_state <= PF_IDLE;
                  end
               end
               PF_DISCARD: begin
                  if (fetch_rvalid) r_state <= PF_IDLE;
               end
               default: r_state <= PF_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && ce) begin
         assert (consume <= r_len);
      end
   end

   assign ipq        = r_ipq;
   assign ipq_len    = r_len;
   assign fetch_req  = r_fetchReq;
   assign fetch_addr = r_fetchAddr;
   assign fetch_word = r_fetchWord;

endmodule

// File: tb/tb_nec_prefetch.sv
// Directed bench for nec_prefetch: a small BIU/memory model serves fetches and a scoreboard
// of expected requests plus a model of the queue contents checks every step.
module tb_nec_prefetch;
   import nec_prefetch_pkg::*;

   typedef struct packed {
      logic [19:0] addr;
      logic        word;
   } req_t;

   logic             clk;
   logic             reset;
   logic             ce;
   logic             flush;
   logic [15:0]      new_pc;
   logic [15:0]      ps;
   logic [3:0]       consume;
   logic [7:0][7:0]  ipq;
   logic [3:0]       ipq_len;
   logic             fetch_req;
   logic [19:0]      fetch_addr;
   logic             fetch_word;
   logic             fetch_ack;
   logic             fetch_rvalid;
   logic [15:0]      fetch_rdata;

   req_t             expQ[$];
   logic [7:0]       expIpq [8];
   int               expLen;
   int               nVectors;
   int               nMiscompares;

   nec_prefetch dut (
      .clk          (clk),
      .reset        (reset),
      .ce           (ce),
      .flush        (flush),
      .new_pc       (new_pc),
      .ps           (ps),
      .consume      (consume),
      .ipq          (ipq),
      .ipq_len      (ipq_len),
      .fetch_req    (fetch_req),
      .fetch_addr   (fetch_addr),
      .fetch_word   (fetch_word),
      .fetch_ack    (fetch_ack),
      .fetch_rvalid (fetch_rvalid),
      .fetch_rdata  (fetch_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] memByte(input logic [19:0] a);
      return a[7:0] ^ {a[15:12], a[19:16]} ^ 8'h3C;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nVectors++;
      assert (observed === expected) else begin
         nMiscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One clock of stimulus: inputs change at the falling edge, outputs are read at the next one.
   task automatic applyStimulus(input logic [3:0] c, input logic f, input logic [15:0] np,
                                input logic a, input logic rv, input logic [15:0] rd);
      consume      = c;
      flush        = f;
      new_pc       = np;
      fetch_ack    = a;
      fetch_rvalid = rv;
      fetch_rdata  = rd;
      @(negedge clk);
      consume      = 4'd0;
      flush        = 1'b0;
      fetch_ack    = 1'b0;
      fetch_rvalid = 1'b0;
   endtask

   task automatic idle();
      applyStimulus(4'd0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
   endtask

   task automatic checkIpq(input string tag);
      for (int i = 0; i < 8; i++)
         checkOutput($sformatf("%s_ipq%0d", tag, i), 32'(ipq[i]), 32'(expIpq[i]));
   endtask

   task automatic expectReq(input string tag, output req_t e);
      e = '0;
      assert (expQ.size() != 0) else begin
         nVectors++;
         nMiscompares++;
         $error("[TB] FAIL %s_sb observed=empty expected=entry", tag);
      end
      if (expQ.size() != 0) e = expQ.pop_front();
      for (int i = 0; i < 20 && fetch_req !== 1'b1; i++) idle();
      checkOutput({tag, "_req"},  32'(fetch_req),  32'd1);
      checkOutput({tag, "_addr"}, 32'(fetch_addr), 32'(e.addr));
      checkOutput({tag, "_word"}, 32'(fetch_word), 32'(e.word));
   endtask

   task automatic serveAfterReq(input string tag, input req_t e, input int delay, input logic [3:0] c);
      logic [15:0] rd;
      logic [2:0]  idx;
      applyStimulus(4'd0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
      checkOutput({tag, "_ackdrop"}, 32'(fetch_req), 32'd0);
      repeat (delay) idle();
      rd = e.word ? {memByte(e.addr + 20'd1), memByte(e.addr)} : {memByte(e.addr), 8'hEE};
      applyStimulus(c, 1'b0, 16'h0, 1'b0, 1'b1, rd);
      idx = e.addr[2:0];
      if (e.word) begin
         expIpq[idx] = rd[7:0];
         idx = idx + 3'd1;
         expIpq[idx] = rd[15:8];
         expLen = expLen - int'(c) + 2;
      end else begin
         expIpq[idx] = rd[15:8];
         expLen = expLen - int'(c) + 1;
      end
      checkOutput({tag, "_len"}, 32'(ipq_len), 32'(expLen));
   endtask

   task automatic serveReq(input string tag, input int delay, input logic [3:0] c);
      req_t e;
      expectReq(tag, e);
      serveAfterReq(tag, e, delay, c);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      req_t e;
      nVectors = 0;
      nMiscompares = 0;
      expLen = 0;
      for (int i = 0; i < 8; i++) expIpq[i] = 8'h00;
      reset = 1'b1;
      ce = 1'b1;
      ps = 16'h1000;
      consume = 4'd0;
      flush = 1'b0;
      new_pc = 16'h0;
      fetch_ack = 1'b0;
      fetch_rvalid = 1'b0;
      fetch_rdata = 16'h0;
      repeat (3) @(negedge clk);

      $display("[TB] reset values");
      checkOutput("rst_len",  32'(ipq_len),    32'd0);
      checkOutput("rst_req",  32'(fetch_req),  32'd0);
      checkOutput("rst_addr", 32'(fetch_addr), 32'd0);
      checkOutput("rst_word", 32'(fetch_word), 32'd0);
      checkIpq("rst");
      reset = 1'b0;

      $display("[TB] sequential fill from ps=0x1000");
      expQ.push_back('{20'h10000, 1'b1});
      expQ.push_back('{20'h10002, 1'b1});
      expQ.push_back('{20'h10004, 1'b1});
      expQ.push_back('{20'h10006, 1'b1});
      expectReq("t1_0", e);
      ce = 1'b0;
      applyStimulus(4'd0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
      applyStimulus(4'd0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
      checkOutput("t1_ce_hold_req", 32'(fetch_req), 32'd1);
      checkOutput("t1_ce_hold_len", 32'(ipq_len),   32'd0);
      ce = 1'b1;
      serveAfterReq("t1_0", e, 1, 4'd0);
      serveReq("t1_1", 0, 4'd0);
      serveReq("t1_2", 2, 4'd0);
      serveReq("t1_3", 0, 4'd0);
      repeat (5) idle();
      checkOutput("t1_full_req", 32'(fetch_req), 32'd0);
      checkOutput("t1_full_len", 32'(ipq_len),   32'd8);
      checkIpq("t1");

      $display("[TB] consume frees room for a word");
      applyStimulus(4'd2, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
      expLen = 6;
      checkOutput("t3_req_next", 32'(fetch_req), 32'd1);
      checkOutput("t3_len",      32'(ipq_len),   32'd6);
      expQ.push_back('{20'h10008, 1'b1});
      serveReq("t3_rv_consume", 0, 4'd2);
      checkIpq("t3");

      $display("[TB] flush to odd pc while request pending");
      expQ.push_back('{20'h1000A, 1'b1});
      expectReq("t2_pending", e);
      applyStimulus(4'd0, 1'b1, 16'h0003, 1'b0, 1'b0, 16'h0);
      expLen = 0;
      checkOutput("t2_flush_req", 32'(fetch_req), 32'd0);
      checkOutput("t2_flush_len", 32'(ipq_len),   32'd0);
      expQ.push_back('{20'h10003, 1'b0});
      serveReq("t2_byte", 0, 4'd0);
      checkOutput("t2_ipq3", 32'(ipq[3]), 32'(memByte(20'h10003)));
      expQ.push_back('{20'h10004, 1'b1});
      serveReq("t2_word", 1, 4'd0);
      checkIpq("t2");

      $display("[TB] flush while waiting for data");
      expQ.push_back('{20'h10006, 1'b1});
      expectReq("t4", e);
      applyStimulus(4'd0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
      applyStimulus(4'd0, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0);
      expLen = 0;
      checkOutput("t4_flush_len", 32'(ipq_len), 32'd0);
      repeat (2) idle();
      checkOutput("t4_discard_req", 32'(fetch_req), 32'd0);
      applyStimulus(4'd0, 1'b0, 16'h0, 1'b0, 1'b1, 16'hDEAD);
      checkOutput("t4_stale_len", 32'(ipq_len), 32'd0);
      checkIpq("t4_stale");
      expQ.push_back('{20'h10100, 1'b1});
      serveReq("t4_new", 0, 4'd0);

      $display("[TB] flush coincident with rvalid and with ack");
      expQ.push_back('{20'h10102, 1'b1});
      expectReq("t5a", e);
      applyStimulus(4'd0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
      applyStimulus(4'd0, 1'b1, 16'h0200, 1'b0, 1'b1, 16'hBEEF);
      expLen = 0;
      checkOutput("t5a_len", 32'(ipq_len), 32'd0);
      checkIpq("t5a");
      expQ.push_back('{20'h10200, 1'b1});
      expectReq("t5b", e);
      applyStimulus(4'd0, 1'b1, 16'h0300, 1'b1, 1'b0, 16'h0);
      checkOutput("t5b_req", 32'(fetch_req), 32'd0);
      repeat (3) idle();
      checkOutput("t5b_discard_req", 32'(fetch_req), 32'd0);
      applyStimulus(4'd0, 1'b0, 16'h0, 1'b0, 1'b1, 16'hF00D);
      checkIpq("t5b_stale");
      expQ.push_back('{20'h10300, 1'b1});
      serveReq("t5b_new", 0, 4'd0);

      $display("[TB] segment offset and bus address wrap");
      ps = 16'hF800;
      applyStimulus(4'd0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 16'h0);
      expLen = 0;
      expQ.push_back('{20'h07FFE, 1'b1});
      expQ.push_back('{20'hF8000, 1'b1});
      expQ.push_back('{20'hF8002, 1'b1});
      serveReq("t6_0", 0, 4'd0);
      serveReq("t6_1", 1, 4'd0);
      checkOutput("t6_len", 32'(ipq_len), 32'd4);
      checkIpq("t6");
      serveReq("t6_2", 0, 4'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
